// File: rtl/page_walker.sv
// Two-level page-table walker: L1 then L2 PTE read, translated address to the TLB on an unfault strobe.
// Zero-wait walk gives unfault three cycles after fault is sampled; mem_req/mem_addr hold until mem_ack.
module page_walker #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 12,
  parameter int VPN_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fault,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic [ADDR_W-1:0] ptbr,
  input  logic              fault_clear,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] fault_input,
  output logic              unfault,
  output logic              page_fault,
  output logic              fault_level,
  output logic              busy
);

  localparam int PPN_W = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_RESP,
    S_SETTLE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              settle_q;
  logic [ADDR_W-1:0] va_q;

  logic             pte_v;
  logic             pte_l;
  logic [PPN_W-1:0] pte_ppn;
  logic             unused_bits;

  assign pte_v       = mem_rdata[0];
  assign pte_l       = mem_rdata[1];
  assign pte_ppn     = mem_rdata[ADDR_W-1:OFFSET_W];
  assign unused_bits = ^{ptbr[OFFSET_W-1:0], mem_rdata[OFFSET_W-1:2], va_q[ADDR_W-1:ADDR_W-VPN_W]};

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    unfault    = 1'b0;
    page_fault = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (fault) state_d = S_L1;
      end
      S_L1: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = (pte_v && !pte_l) ? S_L2 : S_ERR;
      end
      S_L2: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = (pte_v && pte_l) ? S_RESP : S_ERR;
      end
      S_RESP: begin
        unfault = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q) state_d = S_IDLE;
      end
      S_ERR: begin
        page_fault = 1'b1;
        if (fault_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mem_addr is registered: the L1 address is built as the walk launches, the L2 one on the L1 ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 1'b0;
      va_q        <= '0;
      mem_addr    <= '0;
      fault_input <= '0;
      fault_level <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (fault) begin
            va_q     <= vaddr;
            mem_addr <= {ptbr[ADDR_W-1:OFFSET_W], vaddr[ADDR_W-1:ADDR_W-VPN_W], 2'b00};
          end
        end
        S_L1: begin
          if (mem_ack) begin
            if (pte_v && !pte_l)
              mem_addr <= {pte_ppn, va_q[OFFSET_W+VPN_W-1:OFFSET_W], 2'b00};
            else
              fault_level <= 1'b0;
          end
        end
        S_L2: begin
          if (mem_ack) begin
            if (pte_v && pte_l)
              fault_input <= {pte_ppn, va_q[OFFSET_W-1:0]};
            else
              fault_level <= 1'b1;
          end
        end
        S_RESP:   settle_q <= 1'b0;
        S_SETTLE: settle_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: vector table of complete walks plus hand sequences for settle, ERR and reset.
module tb_page_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault;
  logic [31:0] vaddr;
  logic [31:0] ptbr;
  logic        fault_clear;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] fault_input;
  logic        unfault;
  logic        page_fault;
  logic        fault_level;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  page_walker #(.ADDR_W(32), .OFFSET_W(12), .VPN_W(10)) dut (
    .clk(clk), .rst(rst), .fault(fault), .vaddr(vaddr), .ptbr(ptbr),
    .fault_clear(fault_clear), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fault_input(fault_input),
    .unfault(unfault), .page_fault(page_fault), .fault_level(fault_level), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ptbr;
    logic [31:0] vaddr;
    logic [31:0] a1;
    logic [31:0] pte1;
    logic [31:0] a2;
    logic [31:0] pte2;
    int          w1;
    int          w2;
    bit          err;
    bit          lvl;
    logic [31:0] fi;
    int          ev_cyc;   // unfault cycle, or first page_fault cycle
    int          req_cyc;  // total cycles with mem_req high
  } vec_t;

  vec_t vt[7];

  initial begin
    // happy path, zero wait
    vt[0] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2001, 32'h0000_2FFC, 32'h1000_0003,
              0, 0, 1'b0, 1'b0, 32'h1000_000A, 3, 2};
    // three wait cycles on each level
    vt[1] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2001, 32'h0000_2FFC, 32'h1000_0003,
              3, 3, 1'b0, 1'b0, 32'h1000_000A, 9, 8};
    // invalid L1
    vt[2] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2000, 32'h0000_2FFC, 32'h1000_0003,
              0, 0, 1'b1, 1'b0, 32'h0, 2, 1};
    // malformed L2 (valid, non-leaf)
    vt[3] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2001, 32'h0000_2FFC, 32'h1000_0001,
              0, 0, 1'b1, 1'b1, 32'h0, 3, 2};
    // other address mix; ptbr low bits and PTE ignored bits set
    vt[4] = '{32'h00AB_C123, 32'h1234_5678, 32'h00AB_C120, 32'h0BEE_FFF1, 32'h0BEE_FD14, 32'hCAFE_5FFF,
              1, 2, 1'b0, 1'b0, 32'hCAFE_5678, 6, 5};
    // L1 marked leaf
    vt[5] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2003, 32'h0000_2FFC, 32'h1000_0003,
              0, 0, 1'b1, 1'b0, 32'h0, 2, 1};
    // L2 invalid with two wait cycles
    vt[6] = '{32'h0000_1000, 32'hFFFF_F00A, 32'h0000_1FFC, 32'h0000_2001, 32'h0000_2FFC, 32'h1000_0002,
              0, 2, 1'b1, 1'b1, 32'h0, 5, 4};
  end

  initial begin
    rst = 1'b0; fault = 1'b0; fault_clear = 1'b0; mem_ack = 1'b0;
    mem_rdata = '0; vaddr = '0; ptbr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {59'd0, mem_req, unfault, page_fault, fault_level, busy}, 64'd0);
    check("reset_data", {mem_addr, fault_input}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      int nreq, cnt, lvl, bad_addr, uf_cnt, uf_cyc, pf_cyc, both, first_req;
      logic busy_a, busy_b;
      logic [31:0] fi_seen;
      nreq = 0; cnt = 0; lvl = 1; bad_addr = 0; uf_cnt = 0; uf_cyc = 0;
      pf_cyc = 0; both = 0; first_req = 0; busy_a = 1'b0; busy_b = 1'b1; fi_seen = '0;
      vaddr = vt[i].vaddr; ptbr = vt[i].ptbr; fault = 1'b1;
      @(negedge clk);
      fault = 1'b0;
      vaddr = 32'h5555_AAAA;
      for (int cyc = 1; cyc <= 14; cyc++) begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        if (mem_req) begin
          nreq++;
          if (first_req == 0) first_req = cyc;
          if (mem_addr !== ((lvl == 1) ? vt[i].a1 : vt[i].a2)) bad_addr++;
          if (cnt == ((lvl == 1) ? vt[i].w1 : vt[i].w2)) begin
            mem_ack = 1'b1;
            mem_rdata = (mem_addr == vt[i].a1) ? vt[i].pte1 :
                        (mem_addr == vt[i].a2) ? vt[i].pte2 : 32'h0;
            cnt = 0;
            lvl = 2;
          end else begin
            cnt++;
          end
        end
        if (unfault) begin
          uf_cnt++;
          if (uf_cyc == 0) begin
            uf_cyc = cyc;
            fi_seen = fault_input;
          end
        end
        if (page_fault && pf_cyc == 0) pf_cyc = cyc;
        if (unfault && page_fault) both++;
        if (cyc == vt[i].ev_cyc + 2) busy_a = busy;
        if (cyc == vt[i].ev_cyc + 3) busy_b = busy;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check($sformatf("v%0d_first_req", i), 64'(first_req), 64'd1);
      check($sformatf("v%0d_req_cycles", i), 64'(nreq), 64'(vt[i].req_cyc));
      check($sformatf("v%0d_addr_stable", i), 64'(bad_addr), 64'd0);
      check($sformatf("v%0d_uf_pf_overlap", i), 64'(both), 64'd0);
      if (!vt[i].err) begin
        check($sformatf("v%0d_unfault_cycle", i), 64'(uf_cyc), 64'(vt[i].ev_cyc));
        check($sformatf("v%0d_unfault_count", i), 64'(uf_cnt), 64'd1);
        check($sformatf("v%0d_fault_input", i), 64'(fi_seen), 64'(vt[i].fi));
        check($sformatf("v%0d_busy_settle", i), {62'd0, busy_a, busy_b}, 64'd2);
        check($sformatf("v%0d_no_pf", i), 64'(pf_cyc), 64'd0);
      end else begin
        check($sformatf("v%0d_pf_cycle", i), 64'(pf_cyc), 64'(vt[i].ev_cyc));
        check($sformatf("v%0d_no_unfault", i), 64'(uf_cnt), 64'd0);
        check($sformatf("v%0d_pf_held", i), {62'd0, page_fault, fault_level}, {62'd0, 1'b1, vt[i].lvl});
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check($sformatf("v%0d_cleared", i), {62'd0, page_fault, busy}, 64'd0);
      end
      @(negedge clk);
    end

    // settle window with fault held, ERR with fault+fault_clear, then reset mid-walk
    vaddr = 32'hFFFF_F00A; ptbr = 32'h0000_1000; fault = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (cyc <= 7) begin
        mem_ack = mem_req;
        mem_rdata = (mem_addr == 32'h0000_1FFC) ? 32'h0000_2001 :
                    (mem_addr == 32'h0000_2FFC) ? 32'h1000_0003 : 32'h0;
      end
      case (cyc)
        3:  check("settle_unfault", {fault_input, 31'd0, unfault}, {32'h1000_000A, 32'd1});
        4:  check("settle_no_req_c4", {63'd0, mem_req}, 64'd0);
        5: begin
          check("settle_no_req_c5", {63'd0, mem_req}, 64'd0);
          vaddr = 32'h0040_2034;
        end
        6:  check("settle_idle_c6", {62'd0, mem_req, busy}, 64'd0);
        7:  check("rewalk_l1", {31'd0, mem_req, mem_addr}, {32'd1, 32'h0000_1004});
        8:  check("rewalk_err", {62'd0, page_fault, fault_level}, 64'd2);
        9: begin
          check("err_held_with_fault", {62'd0, page_fault, mem_req}, 64'd2);
          fault_clear = 1'b1;
        end
        10: begin
          fault_clear = 1'b0;
          check("clear_to_idle", {61'd0, page_fault, busy, mem_req}, 64'd0);
        end
        11: begin
          check("restart_l1", {31'd0, mem_req, mem_addr}, {32'd1, 32'h0000_1004});
          mem_ack = 1'b1;
          mem_rdata = 32'h0000_2001;
        end
        12: begin
          check("restart_l2", {31'd0, mem_req, mem_addr}, {32'd1, 32'h0000_2008});
          fault = 1'b0;
          rst = 1'b0;
        end
        13: begin
          check("midwalk_rst_ctrl", {59'd0, mem_req, unfault, page_fault, fault_level, busy}, 64'd0);
          check("midwalk_rst_data", {mem_addr, fault_input}, 64'd0);
          rst = 1'b1;
          mem_ack = 1'b1;
          mem_rdata = 32'h1000_0003;
        end
        14: check("late_ack_ignored", {29'd0, busy, unfault, mem_req, fault_input}, 64'd0);
        default: ;
      endcase
    end
    mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
